stack_based_alu: RTL and testbench

//  - Parameterised signed stack machine: a LIFO of N-bit two's-complement words plus an adder and a multiplier.
//  - Executes one 3-bit opcode per clock: PUSH, POP, ADD or MUL on the top two entries.
//  - Registered result and signed-overflow flag.
//  - Used as a compute leaf instantiated at 4/8/16/32-bit widths.

---
 rtl/stack_alu_pkg.sv | 9 +
 rtl/stack_mem.sv | 67 ++++++
 rtl/stack_based_alu.sv | 120 ++++++++++++
 tb/tb_stack_based_alu.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack-based ALU: opcode encodings.
package stack_alu_pkg;

    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

endpackage : stack_alu_pkg

// File: rtl/stack_mem.sv
// DEPTH x N register-file LIFO. push alone appends, pop alone removes the
// top, push+pop together replaces the top two entries with wdata (net -1).
// The caller is responsible for only requesting legal operations.
module stack_mem #(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [N-1:0]               wdata,
    output logic [N-1:0]               top,
    output logic [N-1:0]               next,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  mem_r [DEPTH];
    logic [CW-1:0] sp_r;
    logic [CW-1:0] sp_m1_s;
    logic [CW-1:0] sp_m2_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;
    logic [AW-1:0] next_idx_s;

    // Index arithmetic; wraps harmlessly when the stack holds fewer entries.
    always_comb begin
        sp_m1_s    = sp_r - CW'(1);
        sp_m2_s    = sp_r - CW'(2);
        top_idx_s  = sp_m1_s[AW-1:0];
        next_idx_s = sp_m2_s[AW-1:0];
        if (pop) begin
            wr_idx_s = next_idx_s;
        end else begin
            wr_idx_s = sp_r[AW-1:0];
        end
    end

    // Storage write: append on push, overwrite second entry on replacement.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_idx_s] <= wdata;
        end
    end

    // Stack pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= CW'(0);
        end else begin
            case ({push, pop})
                2'b10:   sp_r <= sp_r + CW'(1);
                2'b01:   sp_r <= sp_m1_s;
                2'b11:   sp_r <= sp_m1_s;
                default: sp_r <= sp_r;
            endcase
        end
    end

    assign top   = mem_r[top_idx_s];
    assign next  = mem_r[next_idx_s];
    assign count = sp_r;

endmodule : stack_mem

// File: rtl/stack_based_alu.sv
// Signed stack machine: opcode decode, add/mul datapath with signed
// overflow detection, and registered result/overflow outputs.
module stack_based_alu
    import stack_alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   opcode,
    input  logic [N-1:0] input_data,
    output logic [N-1:0] output_data,
    output logic         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [N-1:0]          top_s;
    logic [N-1:0]          next_s;
    logic [CW-1:0]         count_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  two_s;
    logic                  is_alu_s;
    logic                  alu_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic [N-1:0]          wdata_s;
    logic signed [N-1:0]   a_s;
    logic signed [N-1:0]   b_s;
    logic [N-1:0]          sum_s;
    logic                  add_ovf_s;
    logic signed [2*N-1:0] prod_s;
    logic [N:0]            prod_hi_s;
    logic                  mul_ovf_s;
    logic [N-1:0]          output_data_r;
    logic                  overflow_r;

    stack_mem #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_stack_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .top   (top_s),
        .next  (next_s),
        .count (count_s)
    );

    // Arithmetic on A (second-from-top) and B (top) with overflow flags.
    always_comb begin
        a_s       = $signed(next_s);
        b_s       = $signed(top_s);
        sum_s     = next_s + top_s;
        add_ovf_s = (next_s[N-1] == top_s[N-1]) && (sum_s[N-1] != next_s[N-1]);
        prod_s    = a_s * b_s;
        prod_hi_s = prod_s[2*N-1:N-1];
        mul_ovf_s = !((&prod_hi_s) || (~|prod_hi_s));
    end

    // Opcode decode into stack push/pop requests; illegal ops become no-ops.
    always_comb begin
        empty_s  = (count_s == CW'(0));
        full_s   = (count_s == FULL_C);
        two_s    = (count_s >= CW'(2));
        is_alu_s = (opcode == OP_ADD) || (opcode == OP_MUL);
        alu_ok_s = is_alu_s && two_s;
        push_s   = ((opcode == OP_PUSH) && !full_s) || alu_ok_s;
        pop_s    = ((opcode == OP_POP) && !empty_s) || alu_ok_s;
        if (opcode == OP_MUL) begin
            wdata_s = prod_s[N-1:0];
        end else if (opcode == OP_ADD) begin
            wdata_s = sum_s;
        end else begin
            wdata_s = input_data;
        end
    end

    // Registered result and overflow; held under NOP, PUSH and illegal ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data_r <= {N{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            case (opcode)
                OP_POP: begin
                    if (!empty_s) begin
                        output_data_r <= top_s;
                        overflow_r    <= 1'b0;
                    end
                end
                OP_ADD: begin
                    if (two_s) begin
                        output_data_r <= sum_s;
                        overflow_r    <= add_ovf_s;
                    end
                end
                OP_MUL: begin
                    if (two_s) begin
                        output_data_r <= prod_s[N-1:0];
                        overflow_r    <= mul_ovf_s;
                    end
                end
                default: begin
                    output_data_r <= output_data_r;
                    overflow_r    <= overflow_r;
                end
            endcase
        end
    end

    assign output_data = output_data_r;
    assign overflow    = overflow_r;

endmodule : stack_based_alu

// File: tb/tb_stack_based_alu.sv
// Directed bench for stack_based_alu at 4/8/16/32-bit widths.
module tb_stack_based_alu;
    import stack_alu_pkg::*;

    localparam logic [2:0] OP_NOP = 3'b000;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op4, op8, op16, op32;
    logic [3:0]  d4;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
    logic [3:0]  o4;
    logic [7:0]  o8;
    logic [15:0] o16;
    logic [31:0] o32;
    logic        v4, v8, v16, v32;

    int total;
    int bad;

    stack_based_alu #(.N(4),  .DEPTH(8)) dut4  (.clk(clk), .rst_n(rst_n), .opcode(op4),  .input_data(d4),  .output_data(o4),  .overflow(v4));
    stack_based_alu #(.N(8),  .DEPTH(8)) dut8  (.clk(clk), .rst_n(rst_n), .opcode(op8),  .input_data(d8),  .output_data(o8),  .overflow(v8));
    stack_based_alu #(.N(16), .DEPTH(8)) dut16 (.clk(clk), .rst_n(rst_n), .opcode(op16), .input_data(d16), .output_data(o16), .overflow(v16));
    stack_based_alu #(.N(32), .DEPTH(8)) dut32 (.clk(clk), .rst_n(rst_n), .opcode(op32), .input_data(d32), .output_data(o32), .overflow(v32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given op applied, then back to NOP; #1 after edge.
    task automatic s4(input logic [2:0] op, input logic [3:0] d);
        op4 = op; d4 = d;
        @(posedge clk); #1;
        op4 = OP_NOP;
    endtask

    task automatic s8(input logic [2:0] op, input logic [7:0] d);
        op8 = op; d8 = d;
        @(posedge clk); #1;
        op8 = OP_NOP;
    endtask

    task automatic s16(input logic [2:0] op, input logic [15:0] d);
        op16 = op; d16 = d;
        @(posedge clk); #1;
        op16 = OP_NOP;
    endtask

    task automatic s32(input logic [2:0] op, input logic [31:0] d);
        op32 = op; d32 = d;
        @(posedge clk); #1;
        op32 = OP_NOP;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        op4 = OP_NOP; op8 = OP_NOP; op16 = OP_NOP; op32 = OP_NOP;
        d4 = 4'h0; d8 = 8'h00; d16 = 16'h0000; d32 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o4", 32'(o4), 32'h0);   chk("rst_v4", 32'(v4), 32'h0);
        chk("rst_o8", 32'(o8), 32'h0);   chk("rst_v8", 32'(v8), 32'h0);
        chk("rst_o16", 32'(o16), 32'h0); chk("rst_v16", 32'(v16), 32'h0);
        chk("rst_o32", o32, 32'h0);      chk("rst_v32", 32'(v32), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4-bit: operations on empty stack are no-ops
        s4(OP_POP, 4'h0);
        chk("empty_pop_o", 32'(o4), 32'h0); chk("empty_pop_v", 32'(v4), 32'h0);
        s4(OP_ADD, 4'h0);
        chk("empty_add_o", 32'(o4), 32'h0); chk("empty_add_v", 32'(v4), 32'h0);

        // 4-bit: 3 + 4
        s4(OP_PUSH, 4'd3);
        s4(OP_PUSH, 4'd4);
        s4(OP_ADD, 4'h0);
        chk("add4_o", 32'(o4), 32'h7); chk("add4_v", 32'(v4), 32'h0);
        s4(OP_POP, 4'h0);
        chk("add4_pop", 32'(o4), 32'h7);
        s4(OP_POP, 4'h0);
        chk("add4_depth_empty", 32'(o4), 32'h7);

        // 4-bit: 7 + 1 overflows to -8
        s4(OP_PUSH, 4'd7);
        s4(OP_PUSH, 4'd1);
        s4(OP_ADD, 4'h0);
        chk("add4ov_o", 32'(o4), 32'h8); chk("add4ov_v", 32'(v4), 32'h1);
        s4(OP_ADD, 4'h0);
        chk("add_one_o", 32'(o4), 32'h8); chk("add_one_v", 32'(v4), 32'h1);
        s4(OP_PUSH, 4'd2);
        chk("push_hold_o", 32'(o4), 32'h8); chk("push_hold_v", 32'(v4), 32'h1);
        s4(OP_POP, 4'h0);
        chk("pop_after_ov_o", 32'(o4), 32'h2); chk("pop_after_ov_v", 32'(v4), 32'h0);
        s4(OP_POP, 4'h0);
        chk("pop_sum", 32'(o4), 32'h8);

        // 4-bit MUL: 3*3=9 overflows; -2*3=-6 fits
        s4(OP_PUSH, 4'd3);
        s4(OP_PUSH, 4'd3);
        s4(OP_MUL, 4'h0);
        chk("mul4ov_o", 32'(o4), 32'h9); chk("mul4ov_v", 32'(v4), 32'h1);
        s4(OP_PUSH, 4'hE);
        s4(OP_PUSH, 4'd3);
        s4(OP_MUL, 4'h0);
        chk("mul4_o", 32'(o4), 32'hA); chk("mul4_v", 32'(v4), 32'h0);
        s4(OP_POP, 4'h0);
        chk("mul4_pop1", 32'(o4), 32'hA);
        s4(OP_POP, 4'h0);
        chk("mul4_pop2", 32'(o4), 32'h9);

        // 4-bit: DEPTH+1 pushes, the 9th is dropped
        for (int i = 1; i <= 9; i++) begin
            s4(OP_PUSH, 4'(i));
        end
        chk("full_push_hold", 32'(o4), 32'h9);
        s4(OP_POP, 4'h0);
        chk("full_pop8", 32'(o4), 32'h8);
        s4(OP_POP, 4'h0);
        chk("full_pop7", 32'(o4), 32'h7);

        // 8-bit: -21 * 10 = -210
        s8(OP_PUSH, 8'hEB);
        s8(OP_PUSH, 8'h0A);
        s8(OP_MUL, 8'h00);
        chk("mul8_o", 32'(o8), 32'h2E); chk("mul8_v", 32'(v8), 32'h1);

        // 16-bit: 0x5FFE + 0x5FFE
        s16(OP_PUSH, 16'h5FFE);
        s16(OP_PUSH, 16'h5FFE);
        s16(OP_ADD, 16'h0000);
        chk("add16_o", 32'(o16), 32'hBFFC); chk("add16_v", 32'(v16), 32'h1);

        // 32-bit: 0x85FFF * 15
        s32(OP_PUSH, 32'h00085FFF);
        s32(OP_PUSH, 32'h0000000F);
        s32(OP_MUL, 32'h0);
        chk("mul32_o", o32, 32'h007D9FF1); chk("mul32_v", 32'(v32), 32'h0);

        // Reset mid-sequence: asynchronous clear between edges
        s4(OP_PUSH, 4'd5);
        s4(OP_PUSH, 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_o4", 32'(o4), 32'h0); chk("midrst_v4", 32'(v4), 32'h0);
        chk("midrst_o8", 32'(o8), 32'h0); chk("midrst_v8", 32'(v8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        s4(OP_POP, 4'h0);
        chk("midrst_pop_o", 32'(o4), 32'h0); chk("midrst_pop_v", 32'(v4), 32'h0);
        s8(OP_POP, 8'h00);
        chk("midrst_pop8", 32'(o8), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stack_based_alu
